// File: rtl/mr_trace_pkg.sv
// Shared types for the mr_chips trace buffer: FIFO entry layout and trigger FSM states.
package mr_trace_pkg;

    localparam int unsigned DEF_DEPTH = 16;
    localparam int unsigned PC_W      = 16;
    localparam int unsigned ALU_W     = 16;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [ALU_W-1:0] alu;
    } trace_entry_t;

    typedef enum logic {
        WAIT_TRIG = 1'b0,
        RUN       = 1'b1
    } trig_state_t;

endpackage

// File: rtl/mr_trace_fifo.sv
// Circular trace storage with read/write pointers and occupancy count.
// The head is read straight from storage; when empty it shows the last popped entry.
module mr_trace_fifo
    import mr_trace_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  trace_entry_t       push_data,
    input  logic               pop,
    output trace_entry_t       head,
    output logic               valid,
    output logic [CNT_W-1:0]   count,
    output logic               full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    trace_entry_t       mem_q [DEPTH];
    trace_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Next-state for storage, pointers and count; pointers wrap naturally at DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid = (count_q != '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    // Empty: rd_ptr-1 is the last popped slot and cannot be overwritten until a push.
    assign head  = valid ? mem_q[rd_ptr_q] : mem_q[rd_ptr_q - PTR_W'(1)];

endmodule

// File: rtl/mr_trace_buffer.sv
// Instruction-boundary trace capture for mr_chips with valid/ready drain and sticky overflow.
// Optional PC trigger (WAIT_TRIG -> RUN) enabled by defining MR_TRACE_TRIGGER_EN.
module mr_trace_buffer
    import mr_trace_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [ALU_W-1:0]   alu_in,
    input  logic               cap_en,
    input  logic               clr_ovf,
`ifdef MR_TRACE_TRIGGER_EN
    input  logic [PC_W-1:0]    trig_pc,
    output logic               triggered,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [ALU_W-1:0]   out_alu,
    output logic [CNT_W-1:0]   count,
    output logic               overflow
);

    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic            seen_q, seen_d;
    logic            overflow_q, overflow_d;

    logic            track_req;
    logic            run;
    logic            cap_req;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic            drop;
    trace_entry_t    push_data;
    trace_entry_t    head;

    // A new instruction boundary is any enabled sample whose PC differs from the last one.
    assign track_req = cap_en && (!seen_q || (pc_in != last_pc_q));

`ifdef MR_TRACE_TRIGGER_EN
    trig_state_t state_q, state_d;
    logic        trig_hit;

    assign trig_hit = cap_en && (pc_in == trig_pc);

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_TRIG: if (trig_hit) state_d = RUN;
            RUN:       state_d = RUN;
            default:   state_d = WAIT_TRIG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_TRIG;
        end else begin
            state_q <= state_d;
        end
    end

    // The matching sample is captured in the same cycle the trigger fires.
    assign run       = (state_q == RUN) || trig_hit;
    assign triggered = (state_q == RUN);
`else
    assign run = 1'b1;
`endif

    assign cap_req   = track_req && run;
    assign pop       = out_valid && out_ready;
    assign push      = cap_req && (!fifo_full || pop);
    assign drop      = cap_req && fifo_full && !pop;
    assign push_data = '{pc: pc_in, alu: alu_in};

    always_comb begin
        last_pc_d  = last_pc_q;
        seen_d     = seen_q;
        overflow_d = overflow_q;
        if (track_req) begin
            last_pc_d = pc_in;
            seen_d    = 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_pc_q  <= '0;
            seen_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            last_pc_q  <= last_pc_d;
            seen_q     <= seen_d;
            overflow_q <= overflow_d;
        end
    end

    mr_trace_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .valid     (out_valid),
        .count     (count),
        .full      (fifo_full)
    );

    assign out_pc   = head.pc;
    assign out_alu  = head.alu;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mr_trace_buffer.sv
// Scoreboard bench for mr_trace_buffer; trigger tests run when MR_TRACE_TRIGGER_EN is defined.
module tb_mr_trace_buffer;
    import mr_trace_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      pc_in;
    logic [15:0]      alu_in;
    logic             cap_en;
    logic             clr_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_pc;
    logic [15:0]      out_alu;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [15:0]      trig_val;
`ifdef MR_TRACE_TRIGGER_EN
    logic [15:0]      trig_pc;
    logic             triggered;
    assign trig_pc = trig_val;
`endif

    always #5 clk = ~clk;

    mr_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .alu_in    (alu_in),
        .cap_en    (cap_en),
        .clr_ovf   (clr_ovf),
`ifdef MR_TRACE_TRIGGER_EN
        .trig_pc   (trig_pc),
        .triggered (triggered),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_alu   (out_alu),
        .count     (count),
        .overflow  (overflow)
    );

    int unsigned  n_tests = 0;
    int unsigned  n_fail  = 0;
    trace_entry_t sb[$];
    logic [15:0]  m_last;
    logic         m_seen;
    logic         m_ovf;
    logic         m_run;

`ifdef MR_TRACE_TRIGGER_EN
    localparam logic RUN_AFTER_RESET = 1'b0;
`else
    localparam logic RUN_AFTER_RESET = 1'b1;
`endif

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_last = '0;
        m_seen = 1'b0;
        m_ovf  = 1'b0;
        m_run  = RUN_AFTER_RESET;
    endtask

    // One clock: drive at negedge, check head vs scoreboard, update model, check state after edge.
    task automatic cycle(input logic [15:0] pc, input logic cap, input logic rdy,
                         input logic clr, input logic rst);
        logic         pop;
        logic         track;
        logic         hit;
        logic         req;
        logic         drop;
        trace_entry_t e;
        reset     = rst;
        pc_in     = pc;
        alu_in    = 16'($urandom);
        cap_en    = cap;
        out_ready = rdy;
        clr_ovf   = clr;
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check_eq("head_pc", 32'(out_pc), 32'(sb[0].pc));
            check_eq("head_alu", 32'(out_alu), 32'(sb[0].alu));
        end
        if (rst) begin
            model_reset();
        end else begin
            drop  = 1'b0;
            pop   = rdy && (sb.size() != 0);
            track = cap && (!m_seen || (pc != m_last));
            hit   = cap && (pc == trig_val);
            req   = track && (m_run || hit);
            if (hit) m_run = 1'b1;
            if (pop) void'(sb.pop_front());
            if (track) begin
                m_last = pc;
                m_seen = 1'b1;
            end
            if (req) begin
                if (sb.size() < DEPTH) begin
                    e.pc  = pc;
                    e.alu = alu_in;
                    sb.push_back(e);
                end else begin
                    drop  = 1'b1;
                    m_ovf = 1'b1;
                end
            end
            if (!drop && clr) m_ovf = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("count", 32'(count), 32'(sb.size()));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
`ifdef MR_TRACE_TRIGGER_EN
        check_eq("triggered", 32'(triggered), 32'(m_run));
`endif
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; pc_in = '0; alu_in = '0; cap_en = 1'b0;
        clr_ovf = 1'b0; out_ready = 1'b0; trig_val = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        cycle(16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_pc", 32'(out_pc), 32'd0);
        check_eq("rst_alu", 32'(out_alu), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);

        // Duplicate PC suppression
        cycle(16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(16'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(16'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(16'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("dedupe_count", 32'(count), 32'd3);
        drain(4);

        // Fill to DEPTH and overflow
        for (int i = 16'h10; i <= 16'h20; i++) cycle(16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("fill_count", 32'(count), 32'd16);
        check_eq("fill_ovf", 32'(overflow), 32'd1);
        check_eq("fill_head", 32'(out_pc), 32'h10);

        // Push and pop together at full
        cycle(16'h30, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("full_pp_count", 32'(count), 32'd16);
        check_eq("full_pp_head", 32'(out_pc), 32'h11);
        check_eq("full_pp_ovf", 32'(overflow), 32'd1);

        // clr_ovf alone, then against a concurrent drop
        cycle(16'h30, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("clr_alone", 32'(overflow), 32'd0);
        cycle(16'h31, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("clr_vs_drop", 32'(overflow), 32'd1);
        drain(17);
        cycle(16'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-drain
        for (int i = 16'h50; i <= 16'h55; i++) cycle(16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("pre_rst_count", 32'(count), 32'd5);
        cycle(16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("mid_rst_count", 32'(count), 32'd0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        trig_val = 16'h55;
        cycle(16'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("post_rst_cap", 32'(count), 32'd1);

        // Random traffic with small PC alphabet to exercise dedupe, full and stalls
        for (int i = 0; i < 400; i++) begin
            cycle(16'($urandom_range(0, 5)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), 1'b0);
        end
        drain(DEPTH + 1);

`ifdef MR_TRACE_TRIGGER_EN
        cycle(16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        trig_val = 16'h42;
        for (int i = 16'h40; i <= 16'h45; i++) begin
            cycle(16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            check_eq("trig_state", 32'(triggered), 32'(i >= 16'h42));
        end
        check_eq("trig_count", 32'(count), 32'd4);
        drain(5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
